// File: rtl/hps_report_pkg.sv
`default_nettype none
// ============================================================================
// Module : hps_report_pkg
// Brief  : Shared page geometry, sequencer states and record-word extraction
//          for the HPS extension report page controller.
// Rev    : 1.0
// ============================================================================
package hps_report_pkg;

    localparam int PAGE_WORDS   = 128;
    // Widest record supported: 16 words of 16 bits.
    localparam int MAX_REC_BITS = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    function automatic logic [15:0] rec_word(
        input logic [MAX_REC_BITS-1:0] data,
        input logic [3:0]              k
    );
        return data[{k, 4'b0000} +: 16];
    endfunction

endpackage : hps_report_pkg
`default_nettype wire

// File: rtl/hps_report_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin arbiter; the search starts one past the
//          most recently granted requester and wraps.
// Rev    : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        w_cand    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_cand = IDX_W'((int'(last) + off) % NUM_REQ);
            if (enable && !grant_any && req[w_cand]) begin
                grant[w_cand] = 1'b1;
                grant_idx     = w_cand;
                grant_any     = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/hps_report_ctrl.sv
`default_nettype none
// ============================================================================
// Module : hps_report_ctrl
// Brief  : Arbitrates measurement records into the 128-word HPS report page
//          and publishes the page through the valid/version handshake.
// Rev    : 1.0
// ============================================================================
module hps_report_ctrl
    import hps_report_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int REC_WORDS = 4
) (
    input  logic                            clk_sys,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*REC_WORDS*16-1:0] req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            commit,
    input  logic                            clear,
    output logic                            hps_valid,
    output logic [1:0]                      hps_wr,
    output logic [15:0]                     hps_din,
    output logic [6:0]                      hps_addr,
    output logic [5:0]                      rec_count,
    output logic                            full
);

    localparam int         c_IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int         c_REC_BITS  = REC_WORDS * 16;
    localparam int         c_REC_SHIFT = $clog2(REC_WORDS);
    localparam logic [7:0] c_FULL_AT   = 8'(PAGE_WORDS - REC_WORDS);
    localparam logic [7:0] c_REC_INC   = 8'(REC_WORDS);
    localparam logic [3:0] c_LAST_WORD = 4'(REC_WORDS - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [7:0]              r_wptr;
    logic [3:0]              r_wcnt;
    logic                    r_dirty;
    logic                    r_commit_pend;
    logic [c_IDX_W-1:0]      r_rr_last;
    logic [c_REC_BITS-1:0]   r_rec;

    logic                    w_full;
    logic                    w_commit_req;
    logic                    w_arb_en;
    logic                    w_grant_any;
    logic                    w_last_word;
    logic [NUM_REQ-1:0]      w_grant;
    logic [c_IDX_W-1:0]      w_grant_idx;
    logic [c_REC_BITS-1:0]   w_sel_rec;
    logic [MAX_REC_BITS-1:0] w_sel_ext;
    logic [MAX_REC_BITS-1:0] w_rec_ext;
    logic [7:0]              w_wptr_inc;
    logic [3:0]              w_wcnt_inc;

    assign w_full       = (r_wptr > c_FULL_AT);
    assign w_commit_req = commit | r_commit_pend;
    assign w_wptr_inc   = r_wptr + c_REC_INC;
    assign w_wcnt_inc   = r_wcnt + 4'd1;

    assign full         = w_full;
    assign rec_count    = 6'(r_wptr >> c_REC_SHIFT);
    assign req_ready    = w_grant;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .IDX_W     (c_IDX_W)
    ) u_arb (
        .req       (req_valid),
        .enable    (w_arb_en),
        .last      (r_rr_last),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .grant_any (w_grant_any)
    );

    // The grant is one-hot, so an OR-mux picks the winning record.
    always_comb begin
        w_sel_rec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_rec = req_data[i*c_REC_BITS +: c_REC_BITS];
            end
        end
    end

    always_comb begin
        w_sel_ext                   = '0;
        w_sel_ext[c_REC_BITS-1:0]   = w_sel_rec;
        w_rec_ext                   = '0;
        w_rec_ext[c_REC_BITS-1:0]   = r_rec;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A pending or fresh commit outranks new grants while in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_arb_en     = 1'b0;
        w_last_word  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (clear) begin
                    w_state_next = IDLE;
                end else if (w_commit_req) begin
                    if (r_dirty || !hps_valid) begin
                        w_state_next = PUBLISH;
                    end
                end else begin
                    w_arb_en = !w_full;
                    if (w_grant_any) begin
                        w_state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                if (r_wcnt == c_LAST_WORD) begin
                    w_last_word  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            PUBLISH: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (clear) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_wptr        <= '0;
            r_wcnt        <= '0;
            r_dirty       <= 1'b0;
            r_commit_pend <= 1'b0;
            r_rr_last     <= c_IDX_W'(NUM_REQ - 1);
            r_rec         <= '0;
            hps_valid     <= 1'b0;
            hps_wr        <= 2'b00;
            hps_din       <= '0;
            hps_addr      <= '0;
        end else if (clear) begin
            // Words of an aborted record stay in the page beyond wptr.
            r_wptr        <= '0;
            r_dirty       <= 1'b0;
            r_commit_pend <= 1'b0;
            hps_valid     <= 1'b0;
            hps_wr        <= 2'b00;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_commit_req) begin
                        r_commit_pend <= 1'b0;
                    end else if (w_grant_any) begin
                        r_rec     <= w_sel_rec;
                        r_rr_last <= w_grant_idx;
                        r_dirty   <= 1'b1;
                        hps_valid <= 1'b0;
                        r_wcnt    <= '0;
                        hps_wr    <= 2'b11;
                        hps_addr  <= r_wptr[6:0];
                        hps_din   <= rec_word(w_sel_ext, 4'd0);
                    end
                end
                WRITE: begin
                    if (commit) begin
                        r_commit_pend <= 1'b1;
                    end
                    if (w_last_word) begin
                        hps_wr <= 2'b00;
                        r_wptr <= w_wptr_inc;
                        if (w_wptr_inc > c_FULL_AT) begin
                            r_commit_pend <= 1'b1;
                        end
                    end else begin
                        r_wcnt   <= w_wcnt_inc;
                        hps_wr   <= 2'b11;
                        hps_addr <= r_wptr[6:0] + {3'b000, w_wcnt_inc};
                        hps_din  <= rec_word(w_rec_ext, w_wcnt_inc);
                    end
                end
                PUBLISH: begin
                    if (commit) begin
                        r_commit_pend <= 1'b1;
                    end
                    hps_valid <= 1'b1;
                    r_dirty   <= 1'b0;
                end
                default: begin
                    hps_wr <= 2'b00;
                end
            endcase
        end
    end

endmodule : hps_report_ctrl
`default_nettype wire

// File: tb/tb_hps_report_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_hps_report_ctrl
// Brief  : Scoreboard bench for hps_report_ctrl: a transaction-level page
//          model predicts grants, page writes and publish edges.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_hps_report_ctrl;

    localparam int N       = 4;
    localparam int RW      = 4;
    localparam int FULL_AT = 128 - RW;

    logic                 clk_sys = 1'b0;
    logic                 reset   = 1'b1;
    logic [N-1:0]         req_valid = '0;
    logic [N*RW*16-1:0]   req_data  = '0;
    logic [N-1:0]         req_ready;
    logic                 commit = 1'b0;
    logic                 clear  = 1'b0;
    logic                 hps_valid;
    logic [1:0]           hps_wr;
    logic [15:0]          hps_din;
    logic [6:0]           hps_addr;
    logic [5:0]           rec_count;
    logic                 full;

    always #5 clk_sys = ~clk_sys;

    hps_report_ctrl #(
        .NUM_REQ   (N),
        .REC_WORDS (RW)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .commit    (commit),
        .clear     (clear),
        .hps_valid (hps_valid),
        .hps_wr    (hps_wr),
        .hps_din   (hps_din),
        .hps_addr  (hps_addr),
        .rec_count (rec_count),
        .full      (full)
    );

    typedef struct { int cyc; int addr; int data; } wr_t;
    typedef struct { int cyc; int val; } ev_t;

    wr_t wq[$];
    ev_t vq[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    bit  run   = 1'b0;

    // Page model: word pointer, unpublished-change flag, pending publish,
    // published flag, last winner, activity (0 idle, 1 streaming, 2 publishing).
    int m_wptr  = 0;
    int m_dirty = 0;
    int m_pend  = 0;
    int m_valid = 0;
    int m_rr    = N - 1;
    int m_mode  = 0;
    int m_left  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input int act, input int exp);
        total++;
        bad++;
        $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic void push_wr(input int c, input int a, input int d);
        wr_t e;
        e.cyc = c; e.addr = a; e.data = d;
        wq.push_back(e);
    endfunction

    function automatic void push_ev(input int c, input int v);
        ev_t e;
        e.cyc = c; e.val = v;
        vq.push_back(e);
    endfunction

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Reference model: evaluated mid-cycle with this cycle's inputs.
    always @(negedge clk_sys) begin
        if (run) begin
            int exp_ready;
            int g;
            exp_ready = 0;
            g         = -1;
            if (clear) begin
                while (wq.size() > 0 && wq[$].cyc > cyc) void'(wq.pop_back());
                if (m_valid != 0) push_ev(cyc + 1, 0);
                m_wptr = 0; m_dirty = 0; m_pend = 0; m_valid = 0; m_mode = 0;
            end else if (m_mode == 0) begin
                if (commit || m_pend != 0) begin
                    m_pend = 0;
                    if (m_dirty != 0 || m_valid == 0) m_mode = 2;
                end else if (m_wptr <= FULL_AT && req_valid != '0) begin
                    for (int off = 1; off <= N; off++) begin
                        if (g < 0 && ((int'(req_valid) >> ((m_rr + off) % N)) & 1) == 1)
                            g = (m_rr + off) % N;
                    end
                    exp_ready = 1 << g;
                    m_rr      = g;
                    m_dirty   = 1;
                    if (m_valid != 0) begin
                        push_ev(cyc + 1, 0);
                        m_valid = 0;
                    end
                    for (int k = 0; k < RW; k++)
                        push_wr(cyc + 1 + k, m_wptr + k, int'(req_data[(g*RW + k)*16 +: 16]));
                    m_left = RW;
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (commit) m_pend = 1;
                m_left--;
                if (m_left == 0) begin
                    m_wptr += RW;
                    if (m_wptr > FULL_AT) m_pend = 1;
                    m_mode = 0;
                end
            end else begin
                if (commit) m_pend = 1;
                m_valid = 1;
                m_dirty = 0;
                m_mode  = 0;
                push_ev(cyc + 1, 1);
            end
            check("req_ready", int'(req_ready), exp_ready);
        end
    end

    // Monitor: consumes page writes and publish edges as the DUT shows them.
    logic prev_valid = 1'b0;
    always @(posedge clk_sys) begin
        #2;
        if (run) begin
            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                flag("write_missing_addr", -1, wq[0].addr);
                void'(wq.pop_front());
            end
            if (hps_wr != 2'b00) begin
                check("hps_wr", int'(hps_wr), 3);
                if (wq.size() == 0) begin
                    flag("write_unexpected_addr", int'(hps_addr), -1);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("write_cycle", cyc, e.cyc);
                    check("hps_addr", int'(hps_addr), e.addr);
                    check("hps_din", int'(hps_din), e.data);
                end
            end
            while (vq.size() > 0 && vq[0].cyc < cyc) begin
                flag("valid_edge_missing", int'(hps_valid), vq[0].val);
                void'(vq.pop_front());
            end
            if (hps_valid != prev_valid) begin
                if (vq.size() == 0) begin
                    flag("valid_edge_unexpected", int'(hps_valid), int'(prev_valid));
                end else begin
                    ev_t e;
                    e = vq.pop_front();
                    check("valid_edge_cycle", cyc, e.cyc);
                    check("valid_edge_value", int'(hps_valid), e.val);
                end
            end
            prev_valid = hps_valid;
            check("rec_count", int'(rec_count), m_wptr / RW);
            check("full", int'(full), (m_wptr > FULL_AT) ? 1 : 0);
        end
    end

    task automatic drive(input logic [N-1:0] v, input logic cm, input logic cl);
        req_valid = v;
        commit    = cm;
        clear     = cl;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_hps_valid", int'(hps_valid), 0);
        check("rst_hps_wr", int'(hps_wr), 0);
        check("rst_hps_din", int'(hps_din), 0);
        check("rst_hps_addr", int'(hps_addr), 0);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_rec_count", int'(rec_count), 0);
        check("rst_full", int'(full), 0);
        reset = 1'b0;
        run   = 1'b1;

        for (int i = 0; i < N; i++)
            for (int k = 0; k < RW; k++)
                req_data[(i*RW + k)*16 +: 16] = (i == 0) ? 16'((k + 1) * 16'h1111)
                                                         : 16'(16'hA000 + i*16 + k);
        // Single record from requester 0.
        drive(4'b0001, 1'b0, 1'b0);
        idle(6);
        // Requesters 0, 1 and 3 competing.
        repeat (22) drive(4'b1011, 1'b0, 1'b0);
        idle(2);
        // Commit during a record, then a redundant commit.
        drive(4'b0100, 1'b0, 1'b0);
        drive('0, 1'b0, 1'b0);
        drive('0, 1'b1, 1'b0);
        idle(8);
        drive('0, 1'b1, 1'b0);
        idle(3);
        // New record after publish, then republish.
        drive(4'b0010, 1'b0, 1'b0);
        idle(6);
        drive('0, 1'b1, 1'b0);
        idle(4);
        // Clear together with commit on the second word of a record.
        drive(4'b0001, 1'b0, 1'b0);
        drive('0, 1'b0, 1'b0);
        drive('0, 1'b1, 1'b1);
        idle(3);
        drive(4'b0001, 1'b0, 1'b0);
        idle(6);

        // Fill phase: no clears, so the page fills, auto-publishes and stalls.
        for (int c = 0; c < 400; c++) begin
            for (int j = 0; j < N*RW/2; j++) req_data[j*32 +: 32] = $urandom;
            drive(4'($urandom), ($urandom_range(99) < 2), 1'b0);
        end
        drive('0, 1'b0, 1'b1);
        idle(2);

        // Mixed phase.
        for (int c = 0; c < 2500; c++) begin
            for (int j = 0; j < N*RW/2; j++) req_data[j*32 +: 32] = $urandom;
            drive(4'($urandom), ($urandom_range(99) < 8), ($urandom_range(99) < 2));
        end
        idle(12);
        run = 1'b0;
        check("writes_outstanding", wq.size(), 0);
        check("valid_edges_outstanding", vq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hps_report_ctrl
`default_nettype wire
